// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, ALU selects and FSM states shared by the ALU sequencer
package alu_seq_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_XOR = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SHL = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_XOR = 2'b01;
    localparam logic [1:0] SEL_ADD = 2'b10;
    localparam logic [1:0] SEL_SHL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MUL_ADD,
        MUL_SHL,
        DONE
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences single-cycle ALU ops and shift-and-add MUL through an external 8-bit ALU
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_sel,
    input  logic [W-1:0] alu_out,
    input  logic         alu_cout,
    input  logic         alu_zero,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_carry,
    output logic         res_zero,
    output logic         res_err,
    output logic         busy
);

    seq_state_t   state;
    logic [1:0]   opSel;
    logic [W-1:0] mcand;
    logic [W-1:0] mplier;
    logic [W-1:0] acc;
    logic         addStep;

    // mcand/mplier double as the A/B operand registers for single-cycle ops
    assign addStep   = state == MUL_ADD && mplier[0];
    assign cmd_ready = state == IDLE && !rst;
    assign busy      = state != IDLE;

    // ALU sees real operands only in cycles that issue an operation, zeros otherwise
    always_comb begin
        alu_sel = state == EXEC ? opSel : addStep ? SEL_ADD : state == MUL_SHL ? SEL_SHL : SEL_AND;
        alu_a   = (state == EXEC || state == MUL_SHL) ? mcand : addStep ? acc : '0;
        alu_b   = state == EXEC ? mplier : addStep ? mcand : '0;
    end

    // Command FSM; MUL finishes on the shift that empties the multiplier to keep latency at 2k+1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            opSel     <= SEL_AND;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        opSel  <= cmd_op[1:0];
                        mcand  <= cmd_a;
                        mplier <= cmd_b;
                        acc    <= '0;
                        if (cmd_op <= OP_SHL) begin
                            state <= EXEC;
                        end else if (cmd_op == OP_MUL && cmd_b != '0) begin
                            state <= MUL_ADD;
                        end else begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                            res_data  <= '0;
                            res_carry <= 1'b0;
                            res_zero  <= cmd_op == OP_MUL;
                            res_err   <= cmd_op != OP_MUL;
                        end
                    end
                end
                EXEC: begin
                    state     <= DONE;
                    res_valid <= 1'b1;
                    res_data  <= alu_out;
                    res_carry <= alu_cout;
                    res_zero  <= alu_zero;
                    res_err   <= 1'b0;
                end
                MUL_ADD: begin
                    if (mplier == '0) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_data  <= acc;
                        res_carry <= 1'b0;
                        res_zero  <= acc == '0;
                        res_err   <= 1'b0;
                    end else begin
                        state <= MUL_SHL;
                        if (mplier[0]) acc <= alu_out;
                    end
                end
                MUL_SHL: begin
                    mcand  <= alu_out;
                    mplier <= mplier >> 1;
                    if (mplier[W-1:1] == '0) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_data  <= acc;
                        res_carry <= 1'b0;
                        res_zero  <= acc == '0;
                        res_err   <= 1'b0;
                    end else begin
                        state <= MUL_ADD;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with a behavioural ALU and a reference model of each command
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_cout;
    logic       alu_zero;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_zero;
    logic       res_err;
    logic       busy;
    logic [8:0] aluWide;

    typedef struct {
        logic [7:0] data;
        logic       carry;
        logic       zero;
        logic       err;
        int         lat;
        int         adds;
        int         shls;
        int         acceptCyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   addCnt = 0;
    int   shlCnt = 0;
    int   forceLow = 0;
    int   acceptCyc = 0;
    bit   inFlight = 0;
    bit   seenValid = 0;
    logic [7:0] heldData;

    alu_sequencer #(.W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_zero(res_zero), .res_err(res_err), .busy(busy)
    );

    // Behavioural ALU: AND, XOR, ADD with carry out, SHL with the shifted-out bit as carry
    assign aluWide  = alu_sel == 2'd0 ? {1'b0, alu_a & alu_b} :
                      alu_sel == 2'd1 ? {1'b0, alu_a ^ alu_b} :
                      alu_sel == 2'd2 ? {1'b0, alu_a} + {1'b0, alu_b} : {alu_a, 1'b0};
    assign alu_out  = aluWide[7:0];
    assign alu_cout = aluWide[8];
    assign alu_zero = aluWide[7:0] == 8'd0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: result from plain arithmetic, latency and ALU step counts from the multiplier bits
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   k;
        int   p;
        e = '{data: 8'd0, carry: 1'b0, zero: 1'b0, err: 1'b0, lat: 2, adds: 0, shls: 0, acceptCyc: 0};
        k = 0;
        for (int i = 0; i < 8; i++) if (b[i]) k = i + 1;
        case (op)
            3'd0: e.data = a & b;
            3'd1: e.data = a ^ b;
            3'd2: begin
                p = int'(a) + int'(b);
                e.data = 8'(p % 256);
                e.carry = p > 255;
                e.adds = 1;
            end
            3'd3: begin
                e.data = 8'((int'(a) * 2) % 256);
                e.carry = a >= 8'd128;
                e.shls = 1;
            end
            3'd4: begin
                p = int'(a) * int'(b);
                e.data = 8'(p % 256);
                e.lat = 2 * k + 1;
                e.adds = $countones(b);
                e.shls = k;
            end
            default: begin
                e.err = 1'b1;
                e.lat = 1;
            end
        endcase
        e.zero = !e.err && e.data == 8'd0;
        return e;
    endfunction

    // Drive garbage with cmd_valid high while busy, then the real command once ready
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            cmd_valid = 1;
            cmd_op = 3'($urandom);
            cmd_a = 8'($urandom);
            cmd_b = 8'($urandom);
            n++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 0;
        end else begin
            cmd_valid = 1;
            cmd_op = op;
            cmd_a = a;
            cmd_b = b;
            @(posedge clk);
            #1;
            cmd_valid = 0;
            e = model(op, a, b);
            e.acceptCyc = cyc;
            acceptCyc = cyc;
            q.push_back(e);
            inFlight = 1;
            addCnt = 0;
            shlCnt = 0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || inFlight) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || inFlight) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Monitor: handshake/idle checks every cycle, scoreboard pop on the first result cycle
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, !inFlight});
            chk("busy", {31'd0, busy}, {31'd0, inFlight});
            if (!inFlight || res_valid) begin
                chk("alu_idle", {14'd0, alu_a, alu_b, alu_sel}, 32'd0);
            end else begin
                if (alu_sel == 2'd2) addCnt++;
                if (alu_sel == 2'd3) shlCnt++;
            end
            if (res_valid) begin
                if (!seenValid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_result", {31'd0, res_valid}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("data", {24'd0, res_data}, {24'd0, e.data});
                        chk("carry", {31'd0, res_carry}, {31'd0, e.carry});
                        chk("zero", {31'd0, res_zero}, {31'd0, e.zero});
                        chk("err", {31'd0, res_err}, {31'd0, e.err});
                        chk("latency", 32'(cyc - e.acceptCyc + 1), 32'(e.lat));
                        chk("add_cycles", 32'(addCnt), 32'(e.adds));
                        chk("shl_cycles", 32'(shlCnt), 32'(e.shls));
                    end
                    heldData = res_data;
                    seenValid = 1;
                end else begin
                    chk("held_data", {24'd0, res_data}, {24'd0, heldData});
                end
                if (forceLow > 0) begin
                    forceLow--;
                    res_ready = 0;
                end else begin
                    res_ready = $urandom_range(0, 9) < 7;
                end
                if (res_ready) begin
                    inFlight = 0;
                    seenValid = 0;
                end
            end else begin
                res_ready = 1'($urandom_range(0, 1));
                if (inFlight && cyc - acceptCyc > 40) begin
                    chk("result_timeout", {31'd0, res_valid}, 32'd1);
                    q.delete();
                    inFlight = 0;
                end
            end
        end
    end

    initial begin
        rst = 1;
        cmd_valid = 0;
        cmd_op = 0;
        cmd_a = 0;
        cmd_b = 0;
        res_ready = 0;
        repeat (3) @(negedge clk);
        chk("reset_state", {res_valid, res_data, res_carry, res_zero, res_err, busy, cmd_ready, alu_a, alu_b, alu_sel}, 32'd0);
        rst = 0;
        issue(3'd2, 8'hF0, 8'h20);
        issue(3'd1, 8'h5A, 8'h5A);
        issue(3'd4, 8'd13, 8'd11);
        issue(3'd4, 8'd20, 8'd20);
        issue(3'd4, 8'h37, 8'd0);
        issue(3'd3, 8'h81, 8'h00);
        drain();
        forceLow = 5;
        issue(3'd2, 8'h33, 8'h44);
        issue(3'd0, 8'hCC, 8'h0F);
        drain();
        issue(3'd6, 8'hAB, 8'hCD);
        issue(3'd4, 8'hFF, 8'hFF);
        drain();
        issue(3'd4, 8'd5, 8'hFF);
        repeat (4) @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("mid_reset", {res_valid, res_data, res_carry, res_zero, res_err, busy, cmd_ready, alu_a, alu_b, alu_sel}, 32'd0);
        q.delete();
        inFlight = 0;
        seenValid = 0;
        @(negedge clk);
        #1;
        rst = 0;
        issue(3'd4, 8'd13, 8'd11);
        drain();
        for (int i = 0; i < 150; i++) issue(3'($urandom), 8'($urandom), 8'($urandom));
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
